// File: rtl/find_min.sv
// find_min: sequential signed minimum over eight packed 16-bit operands, one element per clock.
// Optional FIND_MIN_INDEX_EN adds the registered min_index output.
module find_min #(
    parameter int N = 8,
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N*W-1:0] numbers,
    output logic           done,
    output logic [W-1:0]   result
`ifdef FIND_MIN_INDEX_EN
    ,
    output logic [2:0]     min_index
`endif
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    state_t         state_q, state_d;
    logic [N*W-1:0] data_q, data_d;
    logic [W-1:0]   min_q, min_d;
    logic [W-1:0]   result_q, result_d;
    logic [2:0]     idx_q, idx_d;
    logic           done_q, done_d;
    logic [W-1:0]   elem, cur_min;
    logic           less;
`ifdef FIND_MIN_INDEX_EN
    logic [2:0]     pos_q, pos_d, min_index_q, min_index_d, cur_pos;
`endif
    assign elem    = data_q[idx_q*W +: W];
    assign less    = $signed(elem) < $signed(min_q);
    assign cur_min = less ? elem : min_q;
`ifdef FIND_MIN_INDEX_EN
    assign cur_pos = less ? idx_q : pos_q;
`endif
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        min_d    = min_q;
        idx_d    = idx_q;
        result_d = result_q;
        done_d   = done_q;
`ifdef FIND_MIN_INDEX_EN
        pos_d       = pos_q;
        min_index_d = min_index_q;
`endif
        case (state_q)
            IDLE: if (start) begin
                data_d  = numbers;
                min_d   = numbers[W-1:0];
                idx_d   = 3'd1;
                state_d = SCAN;
`ifdef FIND_MIN_INDEX_EN
                pos_d   = 3'd0;
`endif
            end
            SCAN: begin
                min_d = cur_min;
                idx_d = idx_q + 3'd1;
`ifdef FIND_MIN_INDEX_EN
                pos_d = cur_pos;
`endif
                // strict less-than keeps the lowest index on ties
                if (idx_q == 3'd7) begin
                    result_d = cur_min;
                    done_d   = 1'b1;
                    state_d  = DONE;
`ifdef FIND_MIN_INDEX_EN
                    min_index_d = cur_pos;
`endif
                end
            end
            DONE: if (!start) begin
                done_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            data_q   <= '0;
            min_q    <= '0;
            idx_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
`ifdef FIND_MIN_INDEX_EN
            pos_q       <= '0;
            min_index_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            min_q    <= min_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            done_q   <= done_d;
`ifdef FIND_MIN_INDEX_EN
            pos_q       <= pos_d;
            min_index_q <= min_index_d;
`endif
        end
    end
    assign done   = done_q;
    assign result = result_q;
`ifdef FIND_MIN_INDEX_EN
    assign min_index = min_index_q;
`endif
endmodule

// File: tb/tb_find_min.sv
// tb_find_min: table-driven vectors plus hand-written handshake, mid-scan and reset sequences for find_min.
module tb_find_min;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] numbers;
    logic         done;
    logic [15:0]  result;
`ifdef FIND_MIN_INDEX_EN
    logic [2:0]   min_index;
`endif
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    find_min dut (
        .clk(clk), .rst_n(rst_n), .start(start), .numbers(numbers),
        .done(done), .result(result)
`ifdef FIND_MIN_INDEX_EN
        , .min_index(min_index)
`endif
    );

    typedef struct {
        string        name;
        logic [127:0] nums;
        logic [15:0]  er;
        logic [2:0]   ei;
    } vec_t;
    vec_t vecs[6];

    function automatic logic [127:0] pack8(input logic [15:0] a0, a1, a2, a3, a4, a5, a6, a7);
        return {a7, a6, a5, a4, a3, a2, a1, a0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_idx(input string name, input logic [2:0] exp);
`ifdef FIND_MIN_INDEX_EN
        check({name, "_idx"}, {29'd0, min_index}, {29'd0, exp});
`endif
    endtask

    // waits for done with a bounded cycle budget; lat counts edges after the capture edge
    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!done && lat < 20);
    endtask

    task automatic do_op(input string name, input logic [127:0] v);
        int lat;
        @(negedge clk);
        numbers = v;
        start = 1'b1;
        @(posedge clk); #1;
        check({name, "_done_after_capture"}, {31'd0, done}, 32'd0);
        wait_done(lat);
        check({name, "_latency"}, lat, 32'd7);
    endtask

    task automatic drop_start(input string name);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        check({name, "_done_fall"}, {31'd0, done}, 32'd0);
    endtask

    task automatic run_vec(input string name, input logic [127:0] v, input logic [15:0] er, input logic [2:0] ei);
        do_op(name, v);
        check({name, "_result"}, {16'd0, result}, {16'd0, er});
        check_idx(name, ei);
        drop_start(name);
    endtask

    logic [127:0] v_base, v_signed, v_other;
    int lat;
    bit bad;

    initial begin
        v_base   = pack8(16'h0010, 16'h0005, 16'h0020, 16'h0003, 16'h0040, 16'h0007, 16'h0100, 16'h0009);
        v_signed = pack8(16'h0001, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0000, 16'h1234, 16'hFF00, 16'h0002);
        v_other  = pack8(16'h0300, 16'h0200, 16'h0100, 16'h0050, 16'h0060, 16'h0070, 16'h0080, 16'h0090);
        vecs[0] = '{"base",   v_base,   16'h0003, 3'd3};
        vecs[1] = '{"signed", v_signed, 16'h8000, 3'd3};
        vecs[2] = '{"ties",   pack8(16'h0042, 16'h0042, 16'h0042, 16'h0042, 16'h0042, 16'h0042, 16'h0042, 16'h0042), 16'h0042, 3'd0};
        vecs[3] = '{"last",   pack8(16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'hFFF0), 16'hFFF0, 3'd7};
        vecs[4] = '{"tie_neg", pack8(16'h0005, 16'h0005, 16'hFFFE, 16'h0005, 16'h0005, 16'h0005, 16'hFFFE, 16'h0005), 16'hFFFE, 3'd2};
        vecs[5] = '{"first",  pack8(16'h8000, 16'h7FFF, 16'h8001, 16'h0000, 16'hFFFF, 16'h8001, 16'h7FFE, 16'h8000), 16'h8000, 3'd0};

        rst_n = 1'b0;
        start = 1'b0;
        numbers = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", {16'd0, result}, 32'd0);
        check_idx("reset", 3'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i].name, vecs[i].nums, vecs[i].er, vecs[i].ei);

        // numbers churns and start drops while scanning
        @(negedge clk);
        numbers = v_base;
        start = 1'b1;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            numbers = lat[0] ? {8{16'h8000}} : {$urandom(), $urandom(), $urandom(), $urandom()};
            if (lat >= 1) start = 1'b0;
            @(posedge clk); #1;
            lat++;
        end while (!done && lat < 20);
        check("midscan_latency", lat, 32'd7);
        check("midscan_result", {16'd0, result}, 32'h0003);
        check_idx("midscan", 3'd3);
        @(posedge clk); #1;
        check("midscan_done_fall", {31'd0, done}, 32'd0);
        bad = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) bad = 1;
        end
        check("midscan_idle_stays", {31'd0, bad}, 32'd0);

        // reset three cycles into a scan
        @(negedge clk);
        numbers = v_signed;
        start = 1'b1;
        @(posedge clk);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        check("scanrst_done", {31'd0, done}, 32'd0);
        check("scanrst_result", {16'd0, result}, 32'd0);
        check_idx("scanrst", 3'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec("after_rst", v_signed, 16'h8000, 3'd3);

        // start held through DONE must not retrigger
        do_op("hold", v_base);
        check("hold_result", {16'd0, result}, 32'h0003);
        numbers = v_other;
        bad = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (!done || result !== 16'h0003) bad = 1;
        end
        check("hold_stable", {31'd0, bad}, 32'd0);
        drop_start("hold");
        check("hold_result_kept", {16'd0, result}, 32'h0003);
        run_vec("rearm", v_other, 16'h0050, 3'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/find_min.md
# find_min

Sequential minimum-finder over a packed vector of eight 16-bit signed operands. On a start request it captures all eight values, scans them one per clock, and presents the smallest value on `result` with a `done` flag. It is a reduction helper in the attention datapath, used wherever a row or block minimum is needed, for example for range and normalisation bookkeeping.

## Interface
- `N`, default 8: element count; the RTL is fixed at 8.
- `W`, default 16: element width in bits.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  level request; sampled in IDLE.
- `numbers`  input  128  packed operands; element i is `numbers[16*i+15 : 16*i]`, i = 0..7.
- `done`  output  1  result valid; registered.
- `result`  output  16  minimum value, signed two's complement; registered.
- `min_index`  output  3  position of the minimum; present only with `FIND_MIN_INDEX_EN`.

## Operation
- Element encoding is 16-bit signed two's complement. Comparison is signed: 0x8000 is the smallest value, 0x7FFF the largest.
- FSM states are IDLE, SCAN and DONE.
- IDLE:
  - When `start` = 1, capture `numbers` into an internal 128-bit register.
  - Load the running minimum with element 0 and the scan index with 1.
  - Go to SCAN.
- SCAN:
  - Each cycle compare element[idx] with the running minimum. If it is strictly less, replace the minimum (and the index).
  - Increment idx. After idx = 7 is processed, write the final minimum to `result`, set `done` = 1 and go to DONE.
- Ties keep the lowest index, because replacement happens only on a strict less-than.
- DONE:
  - `done` and `result` stay stable while `start` = 1.
  - When `start` = 0, clear `done` and go to IDLE.
  - `result` holds its value until the next scan completes.
- Changes on `numbers` after the capture edge are ignored.
- `start` deasserting during SCAN is ignored; the scan completes and enters DONE.
- `start` held high through DONE never retriggers. A new operation requires `start` to be low for at least one cycle.
- Reset, asynchronous:
  - State goes to IDLE; `done` = 0; `result` = 0x0000; `min_index` = 0.
  - Internal registers are cleared.
  - Reset asserted mid-scan aborts the operation and leaves no partial result.

## Timing
- Edge E0: `start` sampled high in IDLE; operands captured.
- Edges E1..E7: elements 1..7 compared, one per edge.
- Edge E7: `result` is updated and `done` rises.
- Latency is 7 cycles from the capture edge to `done` high. Throughput is one operation per 9 cycles at best, counting the DONE cycle and the start-low cycle.
- `done` is asserted for at least one cycle. It falls on the first edge that samples `start` = 0 in DONE.
- All outputs come directly from flops, with no combinational path from inputs to outputs.

## Configuration
- `FIND_MIN_INDEX_EN`:
  - Defined: adds the 3-bit `min_index` output, registered alongside `result` and valid when `done` = 1. Ties report the lowest index. Resets to 0.
  - Undefined: the port and its index tracking logic do not exist. `result`/`done` behaviour is unchanged.

## Test plan
- Reset-release check: hold reset, release it, raise `start` with elements {0x0010, 0x0005, 0x0020, 0x0003, 0x0040, 0x0007, 0x0100, 0x0009} -> `done` rises 7 cycles after the capture edge with `result` = 0x0003 (`min_index` = 3).
- Signed check: elements {0x0001, 0xFFFF, 0x7FFF, 0x8000, 0x0000, 0x1234, 0xFF00, 0x0002} -> `result` = 0x8000, index 3.
- Ties and edge positions: all eight elements 0x0042 -> `result` = 0x0042, index 0. A minimum 0xFFF0 at element 7 only -> `result` = 0xFFF0, index 7.
- Mid-scan stimulus: change `numbers` every cycle and drop `start` during SCAN -> the result reflects the captured values, `done` still pulses, then the FSM returns to IDLE.
- Reset during SCAN: assert `rst_n` = 0 at cycle 3 of a scan -> `done` = 0 and `result` = 0x0000 immediately; the next `start` runs a clean operation.
- Handshake: keep `start` high after `done` -> `done` stays 1 and there is no second scan. Drop `start` -> `done` = 0 next edge. Raise `start` again -> a new result after 7 cycles.
